// File: rtl/glitch_free_mux_n_pkg.sv
// Shared definitions for the glitch-free N-channel mux: FSM states,
// blanking-mode codes and the counter-width helper.
package glitch_free_mux_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_BLANK  = 2'd2
    } gfm_state_e;

    localparam int unsigned BLANK_HOLD = 0;
    localparam int unsigned BLANK_ZERO = 1;

    function automatic int unsigned cnt_width(input int unsigned stable_cyc,
                                              input int unsigned blank_cyc);
        int unsigned m;
        m = (stable_cyc > blank_cyc) ? stable_cyc : blank_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/glitch_free_mux_n_sel_debounce.sv
// Select debouncer: tracks the candidate channel and how long it has been
// stable, and flags start / abort / commit-request to the owning FSM.
module sel_debounce
    import glitch_free_mux_n_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STABLE_CYC = 3,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CNT_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEL_W-1:0] cur_sel,
    input  logic             idle,
    input  logic             settle,
    output logic [SEL_W-1:0] cand,
    output logic             start,
    output logic             abort,
    output logic             commit_req
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);

    logic [SEL_W-1:0] cand_q;
    logic [CNT_W-1:0] cnt;
    logic             sel_ok;
    logic             match;
    logic             restart;

    always_comb begin
        sel_ok  = {1'b0, sel} < (SEL_W + 1)'(N_CH);
        start   = idle && sel_ok && (sel != cur_sel);
        match   = settle && (sel == cand_q);
        restart = settle && sel_ok && (sel != cand_q) && (sel != cur_sel);
        abort   = settle && (!sel_ok || (sel == cur_sel));
        if (STABLE_CYC == 1)
            commit_req = start;
        else
            commit_req = match && (cnt == STABLE_LAST);
        // The candidate being loaded this edge must be visible for a same-edge commit.
        cand = start ? sel : cand_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= '0;
            cnt    <= '0;
        end else if (start) begin
            cand_q <= sel;
            cnt    <= (STABLE_CYC == 1) ? '0 : CNT_W'(1);
        end else if (commit_req) begin
            cnt <= '0;
        end else if (match) begin
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
        end else if (restart) begin
            cand_q <= sel;
            cnt    <= CNT_W'(1);
        end else if (abort) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/glitch_free_mux_n.sv
// N-channel registered mux whose select commits only after it has been stable,
// followed by an optional break-before-make blanking interval.
module glitch_free_mux_n
    import glitch_free_mux_n_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STABLE_CYC = 3,
    parameter int unsigned BLANK_CYC  = 2,
    parameter int unsigned BLANK_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH*WIDTH-1:0]      in_bus,
    input  logic [$clog2(N_CH)-1:0]    sel,
    output logic [WIDTH-1:0]           z,
    output logic [$clog2(N_CH)-1:0]    cur_sel,
    output logic                       busy,
    output logic                       switched,
    output logic                       sel_err
);

    localparam int unsigned SEL_W = $clog2(N_CH);
    localparam int unsigned CNT_W = cnt_width(STABLE_CYC, BLANK_CYC);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    gfm_state_e       state;
    logic [CNT_W-1:0] blank_cnt;
    logic [WIDTH-1:0] ch [N_CH];
    logic [SEL_W-1:0] cand;
    logic             start;
    logic             abort;
    logic             commit_req;

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++)
            ch[k] = in_bus[k*WIDTH +: WIDTH];
        sel_err = {1'b0, sel} >= (SEL_W + 1)'(N_CH);
    end

    sel_debounce #(
        .N_CH       (N_CH),
        .STABLE_CYC (STABLE_CYC),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .cur_sel    (cur_sel),
        .idle       (state == ST_IDLE),
        .settle     (state == ST_SETTLE),
        .cand       (cand),
        .start      (start),
        .abort      (abort),
        .commit_req (commit_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            blank_cnt <= '0;
            z         <= '0;
            cur_sel   <= '0;
            busy      <= 1'b0;
            switched  <= 1'b0;
        end else begin
            switched <= 1'b0;
            unique case (state)
                ST_IDLE, ST_SETTLE: begin
                    z <= ch[cur_sel];
                    if (commit_req) begin
                        if (BLANK_CYC == 0) begin
                            cur_sel  <= cand;
                            switched <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            blank_cnt <= '0;
                            state     <= ST_BLANK;
                            busy      <= 1'b1;
                        end
                    end else if (start) begin
                        state <= ST_SETTLE;
                        busy  <= 1'b1;
                    end else if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_BLANK: begin
                    if (BLANK_MODE == BLANK_ZERO)
                        z <= '0;
                    if (blank_cnt == BLANK_LAST) begin
                        cur_sel  <= cand;
                        switched <= 1'b1;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        blank_cnt <= (blank_cnt == '1) ? blank_cnt : blank_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_free_mux_n.sv
// Scoreboard bench: directed select sequences push per-edge expectations,
// a monitor pops and compares them one time unit after each rising edge.
module tb_glitch_free_mux_n;

    typedef struct {
        bit         use_b;
        logic [7:0] z;
        logic [2:0] cur;
        bit         busy;
        bit         sw;
        bit         err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_a = {8'h31, 8'h21, 8'h11, 8'h01};
    logic [39:0] bus_b = {8'h41, 8'h31, 8'h21, 8'h11, 8'h01};
    logic [1:0]  sel_a = '0;
    logic [2:0]  sel_b = '0;
    logic [7:0]  z_a, z_b;
    logic [1:0]  cur_a;
    logic [2:0]  cur_b;
    logic        busy_a, busy_b, sw_a, sw_b, err_a, err_b;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    glitch_free_mux_n #(
        .WIDTH(8), .N_CH(4), .STABLE_CYC(3), .BLANK_CYC(2), .BLANK_MODE(0)
    ) dut_a (
        .clk(clk), .reset(reset), .in_bus(bus_a), .sel(sel_a), .z(z_a),
        .cur_sel(cur_a), .busy(busy_a), .switched(sw_a), .sel_err(err_a)
    );

    glitch_free_mux_n #(
        .WIDTH(8), .N_CH(5), .STABLE_CYC(3), .BLANK_CYC(0), .BLANK_MODE(1)
    ) dut_b (
        .clk(clk), .reset(reset), .in_bus(bus_b), .sel(sel_b), .z(z_b),
        .cur_sel(cur_b), .busy(busy_b), .switched(sw_b), .sel_err(err_b)
    );

    task automatic step(input bit b, input logic [2:0] s, input bit r,
                        input logic [7:0] ez, input logic [2:0] ec,
                        input bit eb, input bit es, input bit ee);
        exp_t e;
        @(negedge clk);
        reset = r;
        if (b) sel_b = s;
        else   sel_a = s[1:0];
        e.use_b = b; e.z = ez; e.cur = ec; e.busy = eb; e.sw = es; e.err = ee;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                step_no++;
                if (e.use_b) begin
                    chk("b.z",        z_b,                e.z);
                    chk("b.cur_sel",  {5'd0, cur_b},      {5'd0, e.cur});
                    chk("b.busy",     {7'd0, busy_b},     {7'd0, e.busy});
                    chk("b.switched", {7'd0, sw_b},       {7'd0, e.sw});
                    chk("b.sel_err",  {7'd0, err_b},      {7'd0, e.err});
                end else begin
                    chk("a.z",        z_a,                e.z);
                    chk("a.cur_sel",  {6'd0, cur_a},      {5'd0, e.cur});
                    chk("a.busy",     {7'd0, busy_a},     {7'd0, e.busy});
                    chk("a.switched", {7'd0, sw_a},       {7'd0, e.sw});
                    chk("a.sel_err",  {7'd0, err_a},      {7'd0, e.err});
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cyc;
        // reset, then idle on channel 0
        step(0, 0, 1, 8'h00, 0, 0, 0, 0);
        step(0, 0, 1, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 8'h01, 0, 0, 0, 0);
        step(0, 0, 0, 8'h01, 0, 0, 0, 0);
        // 0->2 for two samples then back to 0: abort, no switch
        step(0, 2, 0, 8'h01, 0, 1, 0, 0);
        step(0, 2, 0, 8'h01, 0, 1, 0, 0);
        step(0, 0, 0, 8'h01, 0, 0, 0, 0);
        step(0, 0, 0, 8'h01, 0, 0, 0, 0);
        // 0->2 held: commit at e0+4, new data at e0+5, z held through blank
        step(0, 2, 0, 8'h01, 0, 1, 0, 0);
        step(0, 2, 0, 8'h01, 0, 1, 0, 0);
        step(0, 2, 0, 8'h01, 0, 1, 0, 0);
        step(0, 2, 0, 8'h01, 0, 1, 0, 0);
        step(0, 2, 0, 8'h01, 2, 0, 1, 0);
        step(0, 2, 0, 8'h21, 2, 0, 0, 0);
        step(0, 2, 0, 8'h21, 2, 0, 0, 0);
        // 2->1 for two samples, then 3 held: restart counting from the 3
        step(0, 1, 0, 8'h21, 2, 1, 0, 0);
        step(0, 1, 0, 8'h21, 2, 1, 0, 0);
        step(0, 3, 0, 8'h21, 2, 1, 0, 0);
        step(0, 3, 0, 8'h21, 2, 1, 0, 0);
        step(0, 3, 0, 8'h21, 2, 1, 0, 0);
        step(0, 3, 0, 8'h21, 2, 1, 0, 0);
        step(0, 3, 0, 8'h21, 3, 0, 1, 0);
        step(0, 3, 0, 8'h31, 3, 0, 0, 0);
        // 3->0, reset lands during blank
        step(0, 0, 0, 8'h31, 3, 1, 0, 0);
        step(0, 0, 0, 8'h31, 3, 1, 0, 0);
        step(0, 0, 0, 8'h31, 3, 1, 0, 0);
        step(0, 0, 1, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 8'h01, 0, 0, 0, 0);
        step(0, 0, 0, 8'h01, 0, 0, 0, 0);
        // N_CH=5, no blanking, zeroing mode: out-of-range selects are ignored
        step(1, 7, 0, 8'h01, 0, 0, 0, 1);
        step(1, 7, 0, 8'h01, 0, 0, 0, 1);
        step(1, 5, 0, 8'h01, 0, 0, 0, 1);
        // 0->4 commits at e0+2, data at e0+3, z never forced to zero
        step(1, 4, 0, 8'h01, 0, 1, 0, 0);
        step(1, 4, 0, 8'h01, 0, 1, 0, 0);
        step(1, 4, 0, 8'h01, 4, 0, 1, 0);
        step(1, 4, 0, 8'h41, 4, 0, 0, 0);
        // out-of-range select mid-settle aborts
        step(1, 1, 0, 8'h41, 4, 1, 0, 0);
        step(1, 6, 0, 8'h41, 4, 0, 0, 1);
        step(1, 4, 0, 8'h41, 4, 0, 0, 0);
        step(1, 4, 0, 8'h41, 4, 0, 0, 0);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
